arbiter_puf_emu: RTL and testbench

Parametrised, synthesisable arbiter-PUF emulator with a repeated-evaluation controller. It models an N-stage arbiter PUF with the additive delay model: each stage has a signed delay-difference weight, and the challenge controls a running sign. Every request is evaluated N_EVAL times with optional pseudo-random noise, then resolved by majority vote. It sits behind the challenge/response test harness as the next-generation replacement for the single-bit pulse/challenge arbiter: wider challenges, a request/done handshake and a confidence output.

---
 rtl/arbiter_puf_emu_if.sv | 34 +++
 rtl/arbiter_puf_emu.sv | 181 ++++++++++++++++++
 tb/tb_arbiter_puf_emu.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/arbiter_puf_emu_if.sv
`default_nettype none
// ============================================================================
//  Module   : arbiter_puf_emu_if
//  Purpose  : Request/response bundle for the arbiter-PUF emulator.
//             master = requester (drives start/challenge),
//             slave  = emulator  (drives busy/done/response/confidence).
//  Ports    : start, challenge[N_STAGES], busy, done, response,
//             confidence[clog2(N_EVAL+1)]
//  Revision : 1.0 - initial release
// ============================================================================
interface arbiter_puf_emu_if #(
    parameter int N_STAGES = 8,
    parameter int N_EVAL   = 5
);
    localparam int C_CNT_W = $clog2(N_EVAL + 1);

    logic                start;
    logic [N_STAGES-1:0] challenge;
    logic                busy;
    logic                done;
    logic                response;
    logic [C_CNT_W-1:0]  confidence;

    modport master (
        output start, challenge,
        input  busy, done, response, confidence
    );

    modport slave (
        input  start, challenge,
        output busy, done, response, confidence
    );
endinterface
`default_nettype wire

// File: rtl/arbiter_puf_emu.sv
`default_nettype none
// ============================================================================
//  Module   : arbiter_puf_emu
//  Purpose  : N-stage arbiter PUF emulator (additive delay model) with a
//             repeated-evaluation controller and majority vote.
//             Each request is evaluated N_EVAL times: N_STAGES stage cycles
//             followed by one bias cycle per repetition, then a one-cycle
//             DONE state that presents response/confidence.
//  Ports    : clk, rst (sync, active high)
//             bus (slave modport): start, challenge -> busy, done,
//             response, confidence
//  Revision : 1.0 - initial release
// ============================================================================
module arbiter_puf_emu #(
    parameter int          N_STAGES = 8,
    parameter int          DW       = 6,
    parameter int          N_EVAL   = 5,
    parameter int          NOISE_W  = 3,
    parameter logic [15:0] SEED     = 16'h1D0F
) (
    input  wire logic        clk,
    input  wire logic        rst,
    arbiter_puf_emu_if.slave bus
);
    localparam int C_ACC_W = DW + $clog2(N_STAGES + 1) + 2;
    localparam int C_CNT_W = $clog2(N_EVAL + 1);
    localparam int C_STG_W = $clog2(N_STAGES);
    localparam int C_REP_W = (N_EVAL > 1) ? $clog2(N_EVAL) : 1;

    localparam logic [C_STG_W-1:0] C_STG_TOP = C_STG_W'(N_STAGES - 1);
    localparam logic [C_REP_W-1:0] C_REP_TOP = C_REP_W'(N_EVAL - 1);
    localparam logic [C_CNT_W-1:0] C_HALF    = C_CNT_W'(N_EVAL / 2);
    localparam logic [15:0]        C_NSEED   = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [N_STAGES-1:0]        r_creg;
    logic [15:0]                r_wlfsr;
    logic [15:0]                r_nlfsr;
    logic signed [C_ACC_W-1:0]  r_acc;
    logic                       r_phi_neg;   // 1 means phi = -1
    logic                       r_bias;      // 1 during the bias cycle
    logic [C_STG_W-1:0]         r_stage;
    logic [C_REP_W-1:0]         r_rep;
    logic [C_CNT_W-1:0]         r_ones;
    logic [C_CNT_W-1:0]         r_conf;
    logic                       r_resp;

    logic signed [C_ACC_W-1:0]  w_w;
    logic signed [C_ACC_W-1:0]  w_noise;
    logic signed [C_ACC_W-1:0]  w_term;
    logic signed [C_ACC_W-1:0]  w_sum;
    logic                       w_phi_neg_nxt;
    logic                       w_raw;
    logic                       w_last_rep;
    logic [C_CNT_W-1:0]         w_ones_fin;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Current weight, sign-extended to the accumulator width.
    assign w_w = {{(C_ACC_W-DW){r_wlfsr[DW-1]}}, r_wlfsr[DW-1:0]};

    assign w_phi_neg_nxt = r_phi_neg ^ r_creg[r_stage];
    assign w_term        = w_phi_neg_nxt ? -w_w : w_w;

    generate
        if (NOISE_W > 0) begin : g_noise
            logic signed [C_ACC_W-1:0] w_mag;
            assign w_mag   = C_ACC_W'(r_nlfsr[NOISE_W-1:0]);
            assign w_noise = r_nlfsr[15] ? -w_mag : w_mag;
        end else begin : g_no_noise
            assign w_noise = '0;
        end
    endgenerate

    assign w_sum      = r_acc + w_w + w_noise;
    assign w_raw      = ~w_sum[C_ACC_W-1];
    assign w_last_rep = (r_rep == C_REP_TOP);
    assign w_ones_fin = r_ones + C_CNT_W'(w_raw);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start)            w_state_nxt = S_EVAL;
            S_EVAL:  if (r_bias && w_last_rep) w_state_nxt = S_DONE;
            S_DONE:                            w_state_nxt = S_IDLE;
            default:                           w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_creg    <= '0;
            r_wlfsr   <= SEED;
            r_nlfsr   <= C_NSEED;
            r_acc     <= '0;
            r_phi_neg <= 1'b0;
            r_bias    <= 1'b0;
            r_stage   <= C_STG_TOP;
            r_rep     <= '0;
            r_ones    <= '0;
            r_conf    <= '0;
            r_resp    <= 1'b0;
        end else begin
            r_nlfsr <= lfsr_step(r_nlfsr);
            case (r_state)
                S_IDLE: begin
                    r_wlfsr   <= SEED;
                    r_acc     <= '0;
                    r_phi_neg <= 1'b0;
                    r_bias    <= 1'b0;
                    r_stage   <= C_STG_TOP;
                    r_rep     <= '0;
                    r_ones    <= '0;
                    if (bus.start) begin
                        r_creg <= bus.challenge;
                    end
                end
                S_EVAL: begin
                    if (!r_bias) begin
                        r_phi_neg <= w_phi_neg_nxt;
                        r_acc     <= r_acc + w_term;
                        r_wlfsr   <= lfsr_step(r_wlfsr);
                        if (r_stage == '0) begin
                            r_bias <= 1'b1;
                        end else begin
                            r_stage <= r_stage - C_STG_W'(1);
                        end
                    end else begin
                        // Reloading SEED keeps every repetition on the same weights.
                        r_ones    <= w_ones_fin;
                        r_bias    <= 1'b0;
                        r_stage   <= C_STG_TOP;
                        r_acc     <= '0;
                        r_phi_neg <= 1'b0;
                        r_wlfsr   <= SEED;
                        if (!w_last_rep) begin
                            r_rep <= r_rep + C_REP_W'(1);
                        end else begin
                            // Registered here so they are valid in the DONE cycle.
                            r_resp <= (w_ones_fin > C_HALF);
                            r_conf <= w_ones_fin;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy       = (r_state == S_EVAL);
    assign bus.done       = (r_state == S_DONE);
    assign bus.response   = r_resp;
    assign bus.confidence = r_conf;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_puf_emu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_arbiter_puf_emu
//  Purpose  : Self-checking bench for arbiter_puf_emu. Three instances:
//             default (noise on), noise-free default SEED, noise-free with
//             an alternate SEED. Results are compared with an arithmetic
//             delay-sum reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arbiter_puf_emu;
    localparam int          N      = 8;
    localparam int          DW     = 6;
    localparam int          NE     = 5;
    localparam int          NW     = 3;
    localparam logic [15:0] SEED_A = 16'h1D0F;
    localparam logic [15:0] SEED_B = 16'hBEEF;
    localparam int          LAT    = NE * (N + 1) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arbiter_puf_emu_if #(.N_STAGES(N), .N_EVAL(NE)) if_def (), if_nn (), if_sb ();

    arbiter_puf_emu #(.N_STAGES(N), .DW(DW), .N_EVAL(NE), .NOISE_W(NW), .SEED(SEED_A))
        u_dut_def (.clk(clk), .rst(rst), .bus(if_def));
    arbiter_puf_emu #(.N_STAGES(N), .DW(DW), .N_EVAL(NE), .NOISE_W(0), .SEED(SEED_A))
        u_dut_nn (.clk(clk), .rst(rst), .bus(if_nn));
    arbiter_puf_emu #(.N_STAGES(N), .DW(DW), .N_EVAL(NE), .NOISE_W(0), .SEED(SEED_B))
        u_dut_sb (.clk(clk), .rst(rst), .bus(if_sb));

    int n_tests = 0;
    int n_fail  = 0;
    int sel     = 0;

    logic       w_busy, w_done, w_resp;
    logic [2:0] w_conf;
    logic [15:0] r_nlfsr_ref;

    always_comb begin
        w_busy = if_def.busy; w_done = if_def.done;
        w_resp = if_def.response; w_conf = if_def.confidence;
        case (sel)
            1: begin
                w_busy = if_nn.busy; w_done = if_nn.done;
                w_resp = if_nn.response; w_conf = if_nn.confidence;
            end
            2: begin
                w_busy = if_sb.busy; w_done = if_sb.done;
                w_resp = if_sb.response; w_conf = if_sb.confidence;
            end
            default: begin
            end
        endcase
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Noise source runs every cycle from 16'hACE1 after reset.
    always @(posedge clk) begin
        if (rst) r_nlfsr_ref <= 16'hACE1;
        else     r_nlfsr_ref <= lfsr_step(r_nlfsr_ref);
    end

    // idx-th weight drawn from the weight LFSR, as a signed integer.
    function automatic int weight_at(input logic [15:0] seed, input int idx);
        logic [15:0] s;
        int v;
        s = seed;
        for (int i = 0; i < idx; i++) s = lfsr_step(s);
        v = int'(s[DW-1:0]);
        if (v >= (1 << (DW - 1))) v = v - (1 << DW);
        return v;
    endfunction

    // Noise-free delay difference: sum of +/-w over stages plus the bias weight.
    function automatic int delay_diff(input logic [15:0] seed, input logic [N-1:0] chal);
        int d;
        int par;
        d = 0;
        par = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (chal[k]) par = 1 - par;
            d = d + ((par == 1) ? -weight_at(seed, N - 1 - k) : weight_at(seed, N - 1 - k));
        end
        return d + weight_at(seed, N);
    endfunction

    function automatic int noise_of(input logic [15:0] v, input int nw);
        int n;
        if (nw == 0) return 0;
        n = int'(v) & ((1 << nw) - 1);
        return v[15] ? -n : n;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [N-1:0] ch);
        case (sel)
            1:       begin if_nn.start  = st; if_nn.challenge  = ch; end
            2:       begin if_sb.start  = st; if_sb.challenge  = ch; end
            default: begin if_def.start = st; if_def.challenge = ch; end
        endcase
    endtask

    // One request; cycle 1 is the cycle right after the accepting edge.
    task automatic run_req(input int s, input logic [N-1:0] chal, input bit poke,
                           output logic resp_o);
        logic [15:0] seed;
        logic [15:0] nv[NE];
        int  nw, ones, busy_cnt, busy_first, done_cnt, done_at, base;
        bit  overlap;
        logic       resp_d;
        logic [2:0] conf_d;
        sel = s;
        seed = (s == 2) ? SEED_B : SEED_A;
        nw   = (s == 0) ? NW : 0;
        busy_cnt = 0; busy_first = 0; done_cnt = 0; done_at = 0; overlap = 0;
        resp_d = 1'b0; conf_d = 3'd0;
        for (int r = 0; r < NE; r++) nv[r] = 16'h0;
        @(posedge clk); #1;
        drive(1'b1, chal);
        @(posedge clk); #1;
        for (int k = 1; k <= LAT + 4; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            drive(poke && (k == 10 || k == 45 || k == 46), N'($urandom));
            if (w_busy) begin
                busy_cnt++;
                if (busy_first == 0) busy_first = k;
            end
            if (w_done) begin
                done_cnt++; done_at = k; resp_d = w_resp; conf_d = w_conf;
            end
            if (w_busy && w_done) overlap = 1;
            if ((k % (N + 1)) == 0 && k <= NE * (N + 1)) nv[k / (N + 1) - 1] = r_nlfsr_ref;
        end
        drive(1'b0, '0);
        base = delay_diff(seed, chal);
        ones = 0;
        for (int r = 0; r < NE; r++) if (base + noise_of(nv[r], nw) >= 0) ones++;
        check_val("busy_cycles", busy_cnt, NE * (N + 1));
        check_val("busy_first", busy_first, 1);
        check_val("done_count", done_cnt, 1);
        check_val("done_latency", done_at, LAT);
        check_val("busy_done_overlap", overlap, 0);
        check_val("resp_at_done", resp_d, (ones > NE / 2));
        check_val("conf_at_done", conf_d, ones);
        check_val("resp_hold", w_resp, (ones > NE / 2));
        check_val("conf_hold", w_conf, ones);
        resp_o = w_resp;
    endtask

    task automatic reset_mid(input int s, input logic [N-1:0] chal);
        int dones;
        sel = s;
        @(posedge clk); #1;
        drive(1'b1, chal);
        @(posedge clk); #1;
        drive(1'b0, chal);
        for (int k = 2; k <= 20; k++) begin @(posedge clk); #1; end
        check_val("rst_mid_busy_before", w_busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("rst_mid_busy", w_busy, 0);
        check_val("rst_mid_done", w_done, 0);
        check_val("rst_mid_resp", w_resp, 0);
        check_val("rst_mid_conf", w_conf, 0);
        dones = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (w_done) dones++;
        end
        check_val("rst_mid_no_done", dones, 0);
    endtask

    logic [255:0] vec_a, vec_b;
    logic         r_tmp;
    int           spurious;
    int           hit;

    initial begin
        if_def.start = 1'b0; if_def.challenge = '0;
        if_nn.start  = 1'b0; if_nn.challenge  = '0;
        if_sb.start  = 1'b0; if_sb.challenge  = '0;
        vec_a = '0; vec_b = '0;

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            check_val("reset_busy", w_busy, 0);
            check_val("reset_done", w_done, 0);
            check_val("reset_resp", w_resp, 0);
            check_val("reset_conf", w_conf, 0);
        end
        spurious = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (if_def.done || if_nn.done || if_sb.done) spurious++;
        end
        check_val("no_done_without_start", spurious, 0);

        // Latency and noisy model, challenge A5
        run_req(0, 8'hA5, 1'b0, r_tmp);

        // Golden sweeps, both seeds
        for (int c = 0; c < 256; c++) begin
            run_req(1, N'(c), 1'b0, r_tmp);
            vec_a[c] = r_tmp;
        end
        for (int c = 0; c < 256; c++) begin
            run_req(2, N'(c), 1'b0, r_tmp);
            vec_b[c] = r_tmp;
        end
        check_val("seed_vectors_differ", (vec_a != vec_b), 1);

        // Determinism
        run_req(1, 8'h3C, 1'b0, r_tmp);
        run_req(1, 8'h3C, 1'b0, r_tmp);
        run_req(0, 8'h3C, 1'b0, r_tmp);
        run_req(0, 8'h3C, 1'b0, r_tmp);

        // Randomized challenges on the noisy instance, some with start pokes
        for (int i = 0; i < 24; i++) begin
            run_req(0, N'($urandom), (i % 4) == 0, r_tmp);
        end
        run_req(1, 8'h5A, 1'b1, r_tmp);

        // Reset mid-operation after leaving a non-zero result registered
        hit = 0;
        for (int c = 0; c < 256; c++) begin
            if (hit == 0 && delay_diff(SEED_A, N'(c)) >= 0) hit = c + 1;
        end
        if (hit != 0) run_req(1, N'(hit - 1), 1'b0, r_tmp);
        reset_mid(1, 8'hC3);
        run_req(1, 8'hC3, 1'b0, r_tmp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
